// File: rtl/segment_display_if.sv
// Processor-to-display bundle: result nibbles, update strobe and enable in,
// multiplexed anode/cathode drive and frame marker out.
interface segment_display_if;
    logic [3:0] first_segment;
    logic [3:0] second_segment;
    logic       update;
    logic       enable;
    logic [1:0] anode;
    logic [6:0] cathode;
    logic       frame_done;

    modport master (
        output first_segment, second_segment, update, enable,
        input  anode, cathode, frame_done
    );

    modport slave (
        input  first_segment, second_segment, update, enable,
        output anode, cathode, frame_done
    );
endinterface

// File: rtl/segment_display_driver.sv
// Two-digit common-anode seven-segment driver with a shadow buffer that is
// committed only at frame boundaries, plus blanking gaps between digit slots.
module segment_display_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic             fast_clock,
    input  logic             clear,
    segment_display_if.slave bus
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {BLANK_0, SHOW_0, BLANK_1, SHOW_1} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shadow_q;
    logic [7:0]    display_q;
    logic          pending_q;
    logic [1:0]    anode_q;
    logic [6:0]    cathode_q;
    logic          frame_done_q;
    logic          commit;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    // The slot counter runs across blank and show; it restarts on entry to each blank.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            BLANK_0: if (cnt_q == BLANK_LAST) state_d = SHOW_0;
            SHOW_0:  if (cnt_q == SLOT_LAST) begin state_d = BLANK_1; cnt_d = '0; end
            BLANK_1: if (cnt_q == BLANK_LAST) state_d = SHOW_1;
            default: if (cnt_q == SLOT_LAST) begin state_d = BLANK_0; cnt_d = '0; end
        endcase
    end

    assign commit = (state_q == SHOW_1) && (cnt_q == SLOT_LAST);

    // Outputs are computed from the next state so they line up with the state register.
    always_ff @(posedge fast_clock or negedge clear) begin
        if (!clear) begin
            state_q      <= BLANK_0;
            cnt_q        <= '0;
            shadow_q     <= '0;
            display_q    <= '0;
            pending_q    <= 1'b0;
            anode_q      <= 2'b11;
            cathode_q    <= 7'h7F;
            frame_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;

            if (commit) begin
                if (bus.update)
                    display_q <= {bus.second_segment, bus.first_segment};
                else if (pending_q)
                    display_q <= shadow_q;
                pending_q <= 1'b0;
            end else if (bus.update) begin
                shadow_q  <= {bus.second_segment, bus.first_segment};
                pending_q <= 1'b1;
            end

            frame_done_q <= (state_d == SHOW_1) && (cnt_d == SLOT_LAST);

            if (!bus.enable || state_d == BLANK_0 || state_d == BLANK_1) begin
                anode_q   <= 2'b11;
                cathode_q <= 7'h7F;
            end else if (state_d == SHOW_0) begin
                anode_q   <= 2'b10;
                cathode_q <= decode(display_q[3:0]);
            end else begin
                anode_q   <= 2'b01;
                cathode_q <= decode(display_q[7:4]);
            end
        end
    end

    assign bus.anode      = anode_q;
    assign bus.cathode    = cathode_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_segment_display_driver.sv
// Directed bench for segment_display_driver with an 8-cycle slot and 2-cycle blank,
// so one frame is 16 cycles and frame phase is the cycle count modulo 16.
module tb_segment_display_driver;

    logic fast_clock = 1'b0;
    logic clear      = 1'b0;
    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    int   fdCount    = 0;

    logic [7:0] modelDisplay = 8'h00;
    logic [7:0] modelShadow  = 8'h00;
    logic       modelPending = 1'b0;
    logic       enSampled    = 1'b1;

    logic [6:0] decTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    segment_display_if bus ();

    segment_display_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .fast_clock (fast_clock),
        .clear      (clear),
        .bus        (bus)
    );

    always #5 fast_clock = ~fast_clock;

    task automatic checkOutput(input string tag, input logic [1:0] expA,
                               input logic [6:0] expC, input logic expFd);
        checks++;
        assert (bus.anode === expA) else begin
            errors++;
            $error("[TB] FAIL %s anode: observed %b expected %b (cycle %0d)", tag, bus.anode, expA, cyc);
        end
        checks++;
        assert (bus.cathode === expC) else begin
            errors++;
            $error("[TB] FAIL %s cathode: observed %h expected %h (cycle %0d)", tag, bus.cathode, expC, cyc);
        end
        checks++;
        assert (bus.frame_done === expFd) else begin
            errors++;
            $error("[TB] FAIL %s frame_done: observed %b expected %b (cycle %0d)", tag, bus.frame_done, expFd, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] first, input logic [3:0] second);
        bus.first_segment  = first;
        bus.second_segment = second;
        bus.update         = 1'b1;
    endtask

    // One clock: track the frame-boundary commit, then check the whole output set.
    task automatic step();
        int phaseOld;
        int phase;
        phaseOld  = cyc % 16;
        enSampled = bus.enable;
        if (phaseOld == 15 && bus.update) begin
            modelDisplay = {bus.second_segment, bus.first_segment};
            modelPending = 1'b0;
        end else begin
            if (phaseOld == 15 && modelPending) begin
                modelDisplay = modelShadow;
                modelPending = 1'b0;
            end
            if (bus.update) begin
                modelShadow  = {bus.second_segment, bus.first_segment};
                modelPending = 1'b1;
            end
        end
        @(posedge fast_clock);
        cyc++;
        #1 bus.update = 1'b0;
        @(negedge fast_clock);
        phase = cyc % 16;
        if (bus.frame_done === 1'b1) fdCount++;
        if (!enSampled || phase < 2 || phase == 8 || phase == 9)
            checkOutput("model_blank", 2'b11, 7'h7F, phase == 15);
        else if (phase < 8)
            checkOutput("model_show0", 2'b10, decTab[modelDisplay[3:0]], 1'b0);
        else
            checkOutput("model_show1", 2'b01, decTab[modelDisplay[7:4]], phase == 15);
    endtask

    task automatic runTo(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        bus.first_segment  = 4'h0;
        bus.second_segment = 4'h0;
        bus.update         = 1'b0;
        bus.enable         = 1'b1;

        repeat (2) @(negedge fast_clock);
        checkOutput("reset_held", 2'b11, 7'h7F, 1'b0);
        clear = 1'b1;
        cyc   = 0;
        checkOutput("reset_release", 2'b11, 7'h7F, 1'b0);

        // First frame still shows 0/0; the 1/8 update appears from frame 1.
        applyStimulus(4'h1, 4'h8);
        step();
        runTo(5);
        checkOutput("f0_show0", 2'b10, 7'h40, 1'b0);
        runTo(12);
        checkOutput("f0_show1", 2'b01, 7'h40, 1'b0);
        runTo(17);
        checkOutput("f1_blank0", 2'b11, 7'h7F, 1'b0);
        runTo(18);
        checkOutput("f1_show0", 2'b10, 7'h79, 1'b0);

        // Update during SHOW_0 must not tear the current frame.
        runTo(19);
        applyStimulus(4'hA, 4'h8);
        step();
        runTo(22);
        checkOutput("tear_hold", 2'b10, 7'h79, 1'b0);
        runTo(26);
        checkOutput("f1_show1", 2'b01, 7'h00, 1'b0);
        runTo(34);
        checkOutput("tear_new", 2'b10, 7'h08, 1'b0);

        // Update on the very last SHOW_1 cycle bypasses the shadow.
        runTo(47);
        applyStimulus(4'hF, 4'hC);
        step();
        checks++;
        assert (dut.pending_q === 1'b0) else begin
            errors++;
            $error("[TB] FAIL boundary_pending: observed %b expected 0", dut.pending_q);
        end
        runTo(50);
        checkOutput("boundary_show0", 2'b10, 7'h0E, 1'b0);
        runTo(58);
        checkOutput("boundary_show1", 2'b01, 7'h46, 1'b0);

        // Enable low for five sampled edges inside frame 4's SHOW_1.
        runTo(73);
        bus.enable = 1'b0;
        runTo(75);
        checkOutput("disabled", 2'b11, 7'h7F, 1'b0);
        runTo(78);
        bus.enable = 1'b1;
        step();
        checkOutput("reenable", 2'b01, 7'h46, 1'b1);
        runTo(80);
        checks++;
        assert (fdCount === 5) else begin
            errors++;
            $error("[TB] FAIL frame_done_count: observed %0d expected 5", fdCount);
        end

        // Load 9/9, then reset in the middle of SHOW_0.
        runTo(81);
        applyStimulus(4'h9, 4'h9);
        step();
        runTo(98);
        checkOutput("nine_show0", 2'b10, 7'h10, 1'b0);
        runTo(100);
        clear = 1'b0;
        #1;
        checkOutput("async_reset", 2'b11, 7'h7F, 1'b0);
        @(posedge fast_clock);
        @(negedge fast_clock);
        checkOutput("reset_hold", 2'b11, 7'h7F, 1'b0);
        clear        = 1'b1;
        cyc          = 0;
        modelDisplay = 8'h00;
        modelShadow  = 8'h00;
        modelPending = 1'b0;
        runTo(3);
        checkOutput("post_reset_show0", 2'b10, 7'h40, 1'b0);

        // Sweep every nibble through both digits.
        for (int i = 0; i < 16; i++) begin
            runTo(16 * i + 13);
            applyStimulus(4'(i), 4'(15 - i));
            step();
            runTo(16 * (i + 1) + 5);
            checkOutput("sweep_digit0", 2'b10, decTab[i], 1'b0);
            runTo(16 * (i + 1) + 12);
            checkOutput("sweep_digit1", 2'b01, decTab[15 - i], 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/segment_display_driver.md
Name: segment_display_driver

Overview:
- Receiving end of the processor's two 4-bit result nibbles (first_segment, second_segment); drives a 2-digit, common-anode, multiplexed seven-segment display.
- Latches nibbles on an update strobe into a shadow buffer. Commits the buffer at frame boundaries so a frame never shows mixed values.
- Time-multiplexes the two digits with a refresh counter, inserting blanking gaps to suppress ghosting.
- Sits between the microprocessor outputs and the board display pins, clocked by fast_clock (not the divided 1 s clock).

Parameters:
- REFRESH_DIV, 50000, fast_clock cycles per digit slot (blank + show); must exceed BLANK_CYCLES.
- BLANK_CYCLES, 4, cycles at the start of each slot during which both anodes are off; must be >= 1.

Ports:
- fast_clock  input  1  system clock; all logic on its rising edge.
- clear  input  1  asynchronous, active-low reset.
- first_segment  input  4  hex nibble for digit 0 (left).
- second_segment  input  4  hex nibble for digit 1 (right).
- update  input  1  single-cycle strobe; samples both nibbles into the shadow buffer.
- enable  input  1  high = display on; low = all anodes off.
- anode  output  2  active-low digit selects; bit0 = digit 0, bit1 = digit 1.
- cathode  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- frame_done  output  1  one-cycle pulse on the last cycle of SHOW_1.

Behaviour:
- Reset (clear low, asynchronous):
  - state = BLANK_0, slot counter = 0.
  - shadow and display registers = 0, pending = 0.
  - anode = 2'b11, cathode = 7'h7F, frame_done = 0.
- FSM states: BLANK_0 -> SHOW_0 -> BLANK_1 -> SHOW_1 -> BLANK_0.
  - BLANK_x lasts BLANK_CYCLES cycles; SHOW_x lasts REFRESH_DIV - BLANK_CYCLES cycles.
  - Slot counter counts 0..REFRESH_DIV-1 and wraps to 0 when entering BLANK_x.
  - Full frame = 2*REFRESH_DIV cycles.
- Outputs are registered. Their values follow the current state:
  - BLANK_x: anode = 11, cathode = 7'h7F.
  - SHOW_0: anode = 10, cathode = decode(display0).
  - SHOW_1: anode = 01, cathode = decode(display1).
- Decode (active-low, hex):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Update handling:
  - update high: shadow <= {second_segment, first_segment}; pending <= 1.
  - Commit happens on the SHOW_1 -> BLANK_0 transition: if pending, display <= shadow and pending <= 0.
  - update on the same cycle as that transition bypasses the shadow: display takes the live inputs that cycle, and pending stays 0.
  - Repeated updates within one frame: last one wins.
- frame_done asserts on the final SHOW_1 cycle regardless of enable. It is low in every other cycle.
- enable low:
  - anode forced to 11 from the next cycle; cathode forced to 7F.
  - FSM, counter, update and commit logic keep running.
  - Re-enable resumes mid-slot with no restart.
- Reset mid-frame: immediate return to the reset values above. Pending updates are lost.
- No combinational path from inputs to outputs.

Test Plan:
- REFRESH_DIV=8, BLANK_CYCLES=2. Release reset, pulse update with first=1, second=8. Required sequence:
  - first frame shows 0/0: cathode 40 during SHOW_0 and during SHOW_1.
  - from the second frame: SHOW_0 gives anode=10, cathode=79; SHOW_1 gives anode=01, cathode=00.
  - BLANK slots are exactly 2 cycles of anode=11.
- Tearing check: pulse update with first=A during SHOW_0. Required: digit 0 stays at the old value until the next BLANK_0, then shows cathode 08 (A).
- Boundary update: pulse update with first=F, second=C exactly on the final SHOW_1 cycle. Required: the next SHOW_0 shows 0E (F), the next SHOW_1 shows 46 (C), and pending reads 0.
- Drop enable for 5 cycles during SHOW_1. Required:
  - anode=11 and cathode=7F during those cycles.
  - frame_done still pulses once per 16-cycle frame.
  - on re-enable, digit 1 returns without a restart.
- Assert clear mid-SHOW_0 with display=9/9. Required: outputs go to anode=11, cathode=7F, frame_done=0 at once; after release, the first SHOW_0 shows 40.
- Sweep nibbles 0..F over 16 update/frame pairs. Required: cathode matches the decode table for every value on both digits.
